// File: rtl/uart_frame_rx_pkg.sv
// Shared widths, default link parameters and types for the UART luminance receiver.
package uart_frame_rx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;

    // Link defaults: 12 Mbaud on a 48 MHz clock, VGA geometry
    localparam int unsigned DEF_CLKS_PER_BIT = 4;
    localparam int unsigned DEF_IMG_W        = 640;
    localparam int unsigned DEF_IMG_H        = 480;
    localparam int unsigned DEF_IDLE_GAP     = 20000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic              sof;
        logic              eol;
        logic              eof;
    } pix_t;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Serial input plus the pixel stream produced from it.
interface uart_frame_rx_if;
    import uart_frame_rx_pkg::*;

    logic              rx;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic [X_W-1:0]    pix_x;
    logic [Y_W-1:0]    pix_y;
    logic              sof;
    logic              eol;
    logic              eof;
    logic              frame_err;
    logic              short_frame;

    modport master (
        input  rx,
        output pix_data, pix_valid, pix_x, pix_y, sof, eol, eof, frame_err, short_frame
    );

    modport slave (
        output rx,
        input  pix_data, pix_valid, pix_x, pix_y, sof, eol, eof, frame_err, short_frame
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: 2-FF synchroniser, mid-bit sampling, stop-bit error and break hold.
module uart_rx_byte
    import uart_frame_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              byte_done_c_o,
    output logic              stop_err_c_o,
    output logic              line_idle_c_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic              rx_meta_q;
    logic              rxs_q;
    rx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    // IDLE is only ever entered with the line high, so a low rxs there is a falling edge
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        sh_d          = sh_q;
        byte_done_c_o = 1'b0;
        stop_err_c_o  = 1'b0;
        line_idle_c_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                line_idle_c_o = rxs_q;
                cnt_d         = '0;
                if (!rxs_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rxs_q, sh_q[DATA_W-1:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        byte_done_c_o = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        stop_err_c_o = 1'b1;
                        state_d      = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_o = sh_q;

endmodule

// File: rtl/uart_frame_rx.sv
// UART luminance receiver: rebuilds frame geometry from idle-gap alignment and tags each pixel.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned IMG_W        = DEF_IMG_W,
    parameter int unsigned IMG_H        = DEF_IMG_H,
    parameter int unsigned IDLE_GAP     = DEF_IDLE_GAP
) (
    input  logic           clk,
    input  logic           rst,
    uart_frame_rx_if.master bus
);

    localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);

    logic [DATA_W-1:0] rx_data;
    logic              byte_done;
    logic              stop_err;
    logic              line_idle;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (bus.rx),
        .data_o        (rx_data),
        .byte_done_c_o (byte_done),
        .stop_err_c_o  (stop_err),
        .line_idle_c_o (line_idle)
    );

    logic [GAP_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             synced_q, synced_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    pix_t             pix_q, pix_d;
    logic             pix_valid_q, pix_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             short_q, short_d;
    logic             frame_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q  <= '0;
            synced_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            synced_q    <= synced_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            frame_err_q <= frame_err_d;
            short_q     <= short_d;
        end
    end

    // Frame sync fires once, on the cycle the saturating idle counter reaches IDLE_GAP
    always_comb begin
        idle_cnt_d  = '0;
        frame_sync  = 1'b0;
        synced_d    = synced_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_d       = pix_q;
        pix_d.sof   = 1'b0;
        pix_d.eol   = 1'b0;
        pix_d.eof   = 1'b0;
        pix_valid_d = 1'b0;
        frame_err_d = stop_err;
        short_d     = 1'b0;

        if (line_idle) begin
            if (idle_cnt_q == GAP_W'(IDLE_GAP)) begin
                idle_cnt_d = idle_cnt_q;
            end else begin
                idle_cnt_d = idle_cnt_q + GAP_W'(1);
                frame_sync = (idle_cnt_q == GAP_W'(IDLE_GAP - 1));
            end
        end

        if (frame_sync) begin
            short_d  = synced_q && ((x_q != '0) || (y_q != '0));
            synced_d = 1'b1;
            x_d      = '0;
            y_d      = '0;
        end

        if (byte_done && synced_q) begin
            pix_valid_d = 1'b1;
            pix_d.data  = rx_data;
            pix_d.x     = x_q;
            pix_d.y     = y_q;
            pix_d.sof   = (x_q == '0) && (y_q == '0);
            pix_d.eol   = (x_q == X_W'(IMG_W - 1));
            pix_d.eof   = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
            if (x_q == X_W'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_q == Y_W'(IMG_H - 1)) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    assign bus.pix_data    = pix_q.data;
    assign bus.pix_x       = pix_q.x;
    assign bus.pix_y       = pix_q.y;
    assign bus.sof         = pix_q.sof;
    assign bus.eol         = pix_q.eol;
    assign bus.eof         = pix_q.eof;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.short_frame = short_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a 4x3 image and a 50-clock frame gap.
module tb_uart_frame_rx;

    localparam int unsigned CPB = 4;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 3;
    localparam int unsigned GAP = 50;
    // start-bit drive to strobe: 2 sync + 1 edge detect + 2 half bit + 32 data + 4 stop
    localparam int LATENCY = 41;

    typedef struct {
        logic [7:0] d;
        logic [9:0] x;
        logic [8:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
        int         cyc;
    } rec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   fe_cnt;
    int   sf_cnt;
    int   c0;
    int   base;
    rec_t q[$];

    uart_frame_rx_if bus_if ();

    uart_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .IMG_W        (W),
        .IMG_H        (H),
        .IDLE_GAP     (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        fe_cnt = 0;
        sf_cnt = 0;
    end

    always @(negedge clk) begin
        if (bus_if.pix_valid)
            q.push_back('{bus_if.pix_data, bus_if.pix_x, bus_if.pix_y,
                          bus_if.sof, bus_if.eol, bus_if.eof, cyc});
        if (bus_if.frame_err)   fe_cnt = fe_cnt + 1;
        if (bus_if.short_frame) sf_cnt = sf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input int idx, input logic [7:0] d,
                           input int x, input int y, input logic sof, input logic eol,
                           input logic eof);
        if (idx >= q.size()) begin
            check({tag, "_present"}, 32'(q.size()), 32'(idx + 1));
            return;
        end
        check({tag, "_data"}, 32'(q[idx].d), 32'(d));
        check({tag, "_x"}, 32'(q[idx].x), 32'(x));
        check({tag, "_y"}, 32'(q[idx].y), 32'(y));
        check({tag, "_flags"}, 32'({q[idx].sof, q[idx].eol, q[idx].eof}), 32'({sof, eol, eof}));
    endtask

    // Leaves rx high for n clocks and lands just after a falling edge
    task automatic idle(input int n);
        bus_if.rx = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus_if.rx = 1'b0;
        c0 = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_if.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus_if.rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(bus_if.pix_valid), 32'(0));
        check({tag, "_data"}, 32'(bus_if.pix_data), 32'(0));
        check({tag, "_xy"}, 32'({bus_if.pix_x, bus_if.pix_y}), 32'(0));
        check({tag, "_strobes"}, 32'({bus_if.sof, bus_if.eol, bus_if.eof,
                                      bus_if.frame_err, bus_if.short_frame}), 32'(0));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs_zero("reset");

        // 1: first gap only arms sync; first byte lands at (0,0)
        idle(60);
        check("t1_no_short_unsynced", 32'(sf_cnt), 32'(0));
        send_byte(8'hA5, 1'b1);
        idle(5);
        check("t1_count", 32'(q.size()), 32'(1));
        chk_pix("t1", 0, 8'hA5, 0, 0, 1'b1, 1'b0, 1'b0);
        if (q.size() > 0) check("t1_latency", 32'(q[0].cyc - c0), 32'(LATENCY));

        // 2: bad stop bit, then a good byte continues at the old coordinates
        send_byte(8'h3C, 1'b0);
        idle(8);
        check("t2_frame_err", 32'(fe_cnt), 32'(1));
        check("t2_no_valid", 32'(q.size()), 32'(1));
        send_byte(8'h77, 1'b1);
        idle(5);
        chk_pix("t2_next", 1, 8'h77, 1, 0, 1'b0, 1'b0, 1'b0);
        idle(60);
        check("t2_short", 32'(sf_cnt), 32'(1));

        // 3: full 4x3 frame then wrap
        for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b1);
        idle(5);
        check("t3_count", 32'(q.size()), 32'(14));
        for (int i = 0; i < 12; i++)
            chk_pix($sformatf("t3_px%0d", i), 2 + i, 8'(i), i % 4, i / 4,
                    (i == 0), (i % 4 == 3), (i == 11));
        send_byte(8'h5A, 1'b1);
        idle(5);
        chk_pix("t3_wrap", 14, 8'h5A, 0, 0, 1'b1, 1'b0, 1'b0);
        check("t3_no_short_on_wrap", 32'(sf_cnt), 32'(1));

        // 4: gap realigns a partial frame; short_frame strobes once each time
        idle(60);
        check("t4_short_a", 32'(sf_cnt), 32'(2));
        for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i), 1'b1);
        idle(5);
        chk_pix("t4_fifth", 19, 8'h24, 0, 1, 1'b0, 1'b0, 1'b0);
        idle(60);
        check("t4_short_b", 32'(sf_cnt), 32'(3));
        send_byte(8'hC3, 1'b1);
        idle(5);
        chk_pix("t4_resync", 20, 8'hC3, 0, 0, 1'b1, 1'b0, 1'b0);

        // 5: reset drops sync; mid-byte reset loses the byte
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs_zero("t5_reset");
        send_byte(8'h55, 1'b1);
        idle(5);
        check("t5_unsynced_drop", 32'(q.size()), 32'(21));
        bus_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        bus_if.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(60);
        check("t5_midbyte_no_valid", 32'(q.size()), 32'(21));
        check("t5_no_err_short", 32'({fe_cnt[15:0], sf_cnt[15:0]}), 32'({16'd1, 16'd3}));
        send_byte(8'h11, 1'b1);
        idle(5);
        chk_pix("t5_resume", 21, 8'h11, 0, 0, 1'b1, 1'b0, 1'b0);

        // 6: one-clock glitch is rejected and restarts the idle count
        idle(25);
        bus_if.rx = 1'b0;
        @(negedge clk);
        bus_if.rx = 1'b1;
        idle(45);
        check("t6_no_byte", 32'(q.size()), 32'(22));
        check("t6_no_err", 32'(fe_cnt), 32'(1));
        check("t6_gap_restarted", 32'(sf_cnt), 32'(3));
        idle(20);
        check("t6_short_after_gap", 32'(sf_cnt), 32'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
